jtag_ctrl_bank: RTL

//  Multi-channel JTAG-programmable control/status register bank; next generation of the single-word vjtag control port.

---
 rtl/jtag_ctrl_pkg.sv | 30 +++
 rtl/jtag_sync_edge.sv | 39 +++
 rtl/jtag_ctrl_bank.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/jtag_ctrl_pkg.sv
// Shared definitions for the JTAG control/status bank: IR codes, tick FSM states,
// and a clog2 helper that never returns less than one bit.
package jtag_ctrl_pkg;

   localparam logic [2:0] JIR_BYPASS = 3'b000;
   localparam logic [2:0] JIR_DATA   = 3'b001;
   localparam logic [2:0] JIR_ADDR   = 3'b010;
   localparam logic [2:0] JIR_STAT   = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_ACT  = 2'b01,
      S_OUT  = 2'b10
   } tick_state_t;

   function automatic int clog2_min1(input int n);
      int r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Unknown instruction codes behave as BYPASS.
   function automatic logic [2:0] ir_decode(input logic [2:0] code);
      case (code)
         JIR_DATA, JIR_ADDR, JIR_STAT: return code;
         default:                      return JIR_BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchroniser for a bundle of asynchronous TAP signals, with optional
// rising-edge detection (EDGE=1) giving a one-clk pulse per low-to-high transition.
module jtag_sync_edge #(
   parameter int W    = 1,
   parameter bit EDGE = 1'b0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] async_in,
   output logic [W-1:0] sync_d,
   output logic [W-1:0] rise
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= '0;
         sync_d <= '0;
      end else begin
         meta   <= async_in;
         sync_d <= meta;
      end
   end

   generate
      if (EDGE) begin : g_edge
         logic [W-1:0] sync_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) sync_q <= '0;
            else          sync_q <= sync_d;
         end
         assign rise = sync_d & ~sync_q;
      end else begin : g_no_edge
         assign rise = '0;
      end
   endgenerate

endmodule

// File: rtl/jtag_ctrl_bank.sv
// Multi-channel JTAG-programmable control/status register bank, all state in the clk domain.
// Define JTAG_CTRL_AUTOCLR_EN to build per-channel self-clearing of AC_MASK bits after PULSE_CYC clk.
//
// state  | meaning
// S_IDLE | waiting for a synchronised tck rising edge; latches TAP flags on the tick
// S_ACT  | performs the uir/cdr/sdr/udr action using the latched flags
// S_OUT  | loads tdo and drives the ctrl_upd strobe
module jtag_ctrl_bank
   import jtag_ctrl_pkg::*;
#(
   parameter int                NCH       = 4,
   parameter int                DW        = 8,
   parameter logic [NCH*DW-1:0] RST_VAL   = '0,
   parameter int                PULSE_CYC = 16,
   parameter logic [NCH*DW-1:0] AC_MASK   = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tck,
   input  logic              tdi,
   output logic              tdo,
   input  logic [2:0]        ir_in,
   input  logic              cdr,
   input  logic              sdr,
   input  logic              udr,
   input  logic              uir,
   input  logic [NCH*DW-1:0] status_in,
   output logic [NCH*DW-1:0] ctrl_out,
   output logic [NCH-1:0]    ctrl_upd
);

   localparam int          AW    = clog2_min1(NCH);
   localparam int          SW    = (DW > AW) ? DW : AW;
   localparam int unsigned NCH_U = NCH;

   tick_state_t      state;
   logic [2:0]       ir;
   logic [AW-1:0]    addr;
   logic [SW-1:0]    sr;
   logic             byp;
   logic [NCH-1:0]   upd_pend;
   logic [2:0]       f_ir;
   logic             f_cdr, f_sdr, f_udr, f_uir, f_tdi;

   logic             tck_rise;
   logic             unused_tck_lvl;
   logic [7:0]       flag_s;
   logic [7:0]       unused_flag_rise;
   int unsigned      ch_idx;
   logic             in_range;
   logic [DW-1:0]    ctrl_word, stat_word;

   jtag_sync_edge #(.W(1), .EDGE(1'b1)) u_sync_tck (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (tck),
      .sync_d   (unused_tck_lvl),
      .rise     (tck_rise)
   );

   jtag_sync_edge #(.W(8), .EDGE(1'b0)) u_sync_flags (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in ({ir_in, cdr, sdr, udr, uir, tdi}),
      .sync_d   (flag_s),
      .rise     (unused_flag_rise)
   );

   assign ch_idx    = 32'(addr);
   assign in_range  = (ch_idx < NCH_U);
   assign ctrl_word = in_range ? ctrl_out[ch_idx*DW +: DW]  : '0;
   assign stat_word = in_range ? status_in[ch_idx*DW +: DW] : '0;

   // LSB-first shift of a w-bit window; tdi enters at the window MSB.
   function automatic logic [SW-1:0] shift_win(input logic [SW-1:0] v, input logic b, input int w);
      logic [SW-1:0] r;
      r        = v >> 1;
      r[w-1]   = b;
      return r;
   endfunction

`ifdef JTAG_CTRL_AUTOCLR_EN
   localparam int CW = $clog2(PULSE_CYC + 1);
   logic [CW-1:0] ac_cnt [NCH];
`else
   localparam int                unused_pulse_cyc = PULSE_CYC;
   localparam logic [NCH*DW-1:0] unused_ac_mask   = AC_MASK;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         ir       <= JIR_BYPASS;
         addr     <= '0;
         sr       <= '0;
         byp      <= 1'b0;
         tdo      <= 1'b0;
         ctrl_out <= RST_VAL;
         ctrl_upd <= '0;
         upd_pend <= '0;
         f_ir     <= '0;
         {f_cdr, f_sdr, f_udr, f_uir, f_tdi} <= '0;
`ifdef JTAG_CTRL_AUTOCLR_EN
         for (int c = 0; c < NCH; c++) ac_cnt[c] <= '0;
`endif
      end else begin
         ctrl_upd <= '0;
`ifdef JTAG_CTRL_AUTOCLR_EN
         // Expiry clears only masked bits; a JTAG write later in this block overrides it.
         for (int c = 0; c < NCH; c++) begin
            if (ac_cnt[c] != '0) begin
               ac_cnt[c] <= ac_cnt[c] - CW'(1);
               if (ac_cnt[c] == CW'(1))
                  ctrl_out[c*DW +: DW] <= ctrl_out[c*DW +: DW] & ~AC_MASK[c*DW +: DW];
            end
         end
`endif
         case (state)
            S_IDLE: begin
               if (tck_rise) begin
                  {f_ir, f_cdr, f_sdr, f_udr, f_uir, f_tdi} <= flag_s;
                  state <= S_ACT;
               end
            end
            S_ACT: begin
               upd_pend <= '0;
               if (f_uir) begin
                  ir <= ir_decode(f_ir);
               end else if (f_cdr) begin
                  case (ir)
                     JIR_DATA: sr <= SW'(ctrl_word);
                     JIR_STAT: sr <= SW'(stat_word);
                     JIR_ADDR: sr <= SW'(addr);
                     default:  ;
                  endcase
               end else if (f_sdr) begin
                  case (ir)
                     JIR_DATA, JIR_STAT: sr  <= shift_win(sr, f_tdi, DW);
                     JIR_ADDR:           sr  <= shift_win(sr, f_tdi, AW);
                     default:            byp <= f_tdi;
                  endcase
               end else if (f_udr) begin
                  if (ir == JIR_DATA && in_range) begin
                     ctrl_out[ch_idx*DW +: DW] <= sr[DW-1:0];
                     upd_pend[addr]            <= 1'b1;
`ifdef JTAG_CTRL_AUTOCLR_EN
                     ac_cnt[addr]              <= CW'(PULSE_CYC);
`endif
                  end else if (ir == JIR_ADDR) begin
                     addr <= sr[AW-1:0];
                  end
               end
               state <= S_OUT;
            end
            S_OUT: begin
               tdo      <= (ir == JIR_BYPASS) ? byp : sr[0];
               ctrl_upd <= upd_pend;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
